seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial pattern detector: the successor to the fixed-pattern detector in the lab top level. It samples a 1-bit serial stream on an internally generated sample tick. This replaces the divided clock used previously, so the whole block runs on `sys_clk`. It flags matches against a runtime-loadable pattern of programmable length, in overlapping or non-overlapping mode, and keeps a saturating match count that drives the board LEDs.

## Interface
Parameters:
- `PAT_W`, default 8: maximum pattern length in bits; must be ≥ 2.
- `PATTERN`, default 8'b10111001: active pattern after reset, right-aligned. The newest bit is compared against bit 0.
- `OVERLAP`, default 1: overlap mode after reset. 1 means overlapping, 0 means non-overlapping.
- `DIV_N`, default 1: sample tick period in `sys_clk` cycles; must be ≥ 1.
- `CNT_W`, default 8: match counter width.

Ports:
- `sys_clk`, input, 1 bit: the single clock; all state changes on the rising edge.
- `sys_rst_n`, input, 1 bit: asynchronous active-low reset.
- `seq`, input, 1 bit: serial data, sampled on tick edges only.
- `cfg_load`, input, 1 bit: single-cycle strobe that latches the three `cfg_*` inputs below.
- `cfg_pattern`, input, `PAT_W` bits: new pattern, right-aligned.
- `cfg_len`, input, $clog2(PAT_W+1) bits: new pattern length.
- `cfg_overlap`, input, 1 bit: new mode.
- `cnt_clr`, input, 1 bit: synchronous clear of the match counter.
- `ans`, output, 1 bit: match result of the most recent tick, held until the next tick.
- `ans_pulse`, output, 1 bit: one `sys_clk`-wide pulse per match.
- `match_cnt`, output, `CNT_W` bits: saturating match count.
- `LED`, output, 8 bits: `match_cnt[7:0]`, zero-extended if `CNT_W` < 8.

## Operation
- Reset values:
  - `div_cnt` = 0, `hist` = 0, `fill` = 0.
  - `ans` = 0, `ans_pulse` = 0, `match_cnt` = 0, `LED` = 0.
  - Active pattern = `PATTERN`, active length = `PAT_W`, active mode = `OVERLAP`.
- Tick generator:
  - `div_cnt` counts 0 to `DIV_N`-1 and wraps.
  - `tick` = (`div_cnt` == `DIV_N`-1), combinational.
  - With `DIV_N`=1, `tick` is constantly 1.
- History register:
  - On tick, `hist` ← {`hist`[PAT_W-2:0], `seq`}.
  - `fill` ← min(`fill`+1, `PAT_W`).
- Match condition, evaluated on the shifted value h' = {`hist`[PAT_W-2:0], `seq`}:
  - (h' & mask) == (pattern & mask), where mask has the low `len` bits set.
  - And `fill`+1 ≥ `len`.
- On a tick edge:
  - `ans` ← match.
  - `ans_pulse` ← match.
  - If match, `match_cnt` ← `match_cnt`+1, saturating at all-ones.
- On a non-tick edge: `ans` holds, `ans_pulse` ← 0.
- Non-overlapping mode: on a match, `fill` ← 0 instead of incrementing, so the next match needs `len` fresh bits.
- Overlapping mode: `fill` is never cleared by a match.
- Configuration via `cfg_load`:
  - Latches the active pattern, length and mode.
  - Clears `hist`, `fill`, `ans` and `ans_pulse`.
  - Does not affect `match_cnt` or `div_cnt`.
- Length clamp: a `cfg_len` of 0 is treated as 1; a `cfg_len` greater than `PAT_W` is treated as `PAT_W`.
- Simultaneous events:
  - `cfg_load` and tick in the same cycle: the load wins and the sampled bit is discarded.
  - `cnt_clr` and a match in the same cycle: the clear wins and `match_cnt` = 0.
  - `cnt_clr` and `cfg_load` in the same cycle: both take effect.
- Reset mid-operation: asynchronous return to the reset values listed above, including a reload of `PATTERN` and `OVERLAP`.

## Timing
- `seq` must be stable at the rising edge where `tick`=1. Its value at other edges is ignored.
- Latency: the edge that samples the final pattern bit is the edge at which `ans` and `ans_pulse` rise, with no extra cycle. `match_cnt` updates on the same edge.
- Output widths between ticks:
  - `ans` is valid for exactly `DIV_N` `sys_clk` cycles, from one tick edge to the next.
  - `ans_pulse` is high for 1 cycle.
- A `cfg_load` takes effect at its edge. The next tick samples the first bit under the new configuration.
- All outputs are registered with no combinational path from inputs. `LED` is a direct wire of the registered `match_cnt`.

## Test plan
- Defaults with `PAT_W`=8 and `DIV_N`=4: stream 10111001 MSB-first ten times. Expect 10 `ans_pulse` events, 32 `sys_clk` cycles apart; each `ans` high for 4 cycles; final `LED` = 8'h0A.
- `cfg_load` with pattern 4'b1011, `cfg_len`=4, overlap=1, `DIV_N`=1: stream 1011011. Expect matches after bits 4 and 7, `match_cnt` = 2.
- Same stream with overlap=0: expect a single match after bit 4 and `match_cnt` = 1.
- `CNT_W`=4 with 20 matching sequences: `match_cnt` saturates at 15 and `LED` = 8'h0F. Asserting `cnt_clr` in a match cycle then leaves `match_cnt` = 0.
- Issue `cfg_load` on a tick edge midway through a matching sequence. Expect no match for that sequence and `hist`/`fill` cleared; a full new sequence is required. Also check that `cfg_len`=0 detects every bit equal to `cfg_pattern`[0].
- Assert `sys_rst_n` low between clock edges mid-stream. All outputs go to 0 immediately, and the `PATTERN` detection from the first test works again after release.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern of programmable
// length, overlapping or non-overlapping matching, an internal sample tick
// derived from sys_clk, and a saturating match counter mirrored onto LEDs.
module seq_detector_param #(
    parameter int                PAT_W   = 8,
    parameter logic [PAT_W-1:0]  PATTERN = 8'b10111001,
    parameter bit                OVERLAP = 1'b1,
    parameter int                DIV_N   = 1,
    parameter int                CNT_W   = 8,
    localparam int               LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              seq,
    input  logic              cfg_load,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_overlap,
    input  logic              cnt_clr,
    output logic              ans,
    output logic              ans_pulse,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [7:0]        LED
);

    localparam int               DIV_W    = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // The oldest bit of the shifted history is compared but never needs to
    // be kept, so only PAT_W-1 bits are stored.
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [PAT_W-2:0] hist_q,    hist_d;
    logic [LEN_W-1:0] fill_q,    fill_d;
    logic [PAT_W-1:0] pat_q,     pat_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic             ovl_q,     ovl_d;
    logic             ans_q,     ans_d;
    logic             pulse_q,   pulse_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic             tick;
    logic [PAT_W-1:0] h_shift;
    logic [PAT_W-1:0] mask;
    logic             bits_hit;
    logic             enough_bits;
    logic             match;
    logic [LEN_W-1:0] cfg_len_clamped;

    assign tick    = (div_cnt_q == DIV_LAST);
    assign h_shift = {hist_q, seq};

    // Mask covers the low len_q bits: only the newest len_q samples matter.
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
        assign mask[gi] = (LEN_W'(gi) < len_q);
    end

    assign bits_hit    = (((h_shift ^ pat_q) & mask) == '0);
    assign enough_bits = (({1'b0, fill_q} + 1'b1) >= {1'b0, len_q});
    assign match       = bits_hit && enough_bits;

    // Clamp the requested length into 1..PAT_W.
    always_comb begin
        cfg_len_clamped = cfg_len;
        if (cfg_len == '0) begin
            cfg_len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_MAX) begin
            cfg_len_clamped = LEN_MAX;
        end
    end

    // Next-state logic: configuration load beats a tick, counter clear beats
    // a counted match; the tick divider runs regardless of loads.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        ans_d     = ans_q;
        pulse_d   = 1'b0;
        cnt_d     = cnt_q;

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len_clamped;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
            ans_d  = 1'b0;
        end else if (tick) begin
            hist_d = h_shift[PAT_W-2:0];
            if (match && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != LEN_MAX) begin
                fill_d = fill_q + LEN_W'(1);
            end
            ans_d   = match;
            pulse_d = match;
            if (match && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    // State register; reset reloads the power-up pattern, length and mode.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt_q <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= PATTERN;
            len_q     <= LEN_MAX;
            ovl_q     <= OVERLAP;
            ans_q     <= 1'b0;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            ans_q     <= ans_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ans       = ans_q;
    assign ans_pulse = pulse_q;
    assign match_cnt = cnt_q;

    if (CNT_W >= 8) begin : g_led_trunc
        assign LED = cnt_q[7:0];
    end else begin : g_led_ext
        assign LED = {{(8 - CNT_W){1'b0}}, cnt_q};
    end

endmodule
